// File: rtl/fetch_pkg.sv
// Shared state encodings and constants for the instruction fetch stage.
package fetch_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_REQ  = 3'd1,
        ST_WAIT = 3'd2,
        ST_DROP = 3'd3,
        ST_FULL = 3'd4
    } fetch_state_e;

    localparam logic [31:0] FETCH_NOP        = 32'h0000_0013;
    localparam logic [1:0]  FETCH_ALIGN_MASK = 2'b11;

    function automatic logic is_misaligned(input logic [1:0] pc_low);
        return (pc_low & FETCH_ALIGN_MASK) != 2'b00;
    endfunction

endpackage

// File: rtl/fetch_output_reg.sv
// Valid/ready holding register presenting a fetched instruction, its PC and
// fault flag to decode; loads on capture, holds under stall, clears on release.
module fetch_output_reg #(
    parameter int DATA_WIDTH_P = 32,
    parameter int ADDR_WIDTH_P = 32
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    i_load,
    input  logic                    i_clear,
    input  logic [DATA_WIDTH_P-1:0] i_instr,
    input  logic [ADDR_WIDTH_P-1:0] i_pc,
    input  logic                    i_fault,
    output logic                    o_valid,
    output logic [DATA_WIDTH_P-1:0] o_instr,
    output logic [ADDR_WIDTH_P-1:0] o_pc,
    output logic                    o_fault
);

    logic                    valid_q, valid_d;
    logic [DATA_WIDTH_P-1:0] instr_q, instr_d;
    logic [ADDR_WIDTH_P-1:0] pc_q,    pc_d;
    logic                    fault_q, fault_d;

    always_comb begin
        // NOTE: every _d starts as its _q so no path leaves a signal unassigned (no latch).
        valid_d = valid_q;
        instr_d = instr_q;
        pc_d    = pc_q;
        fault_d = fault_q;
        if (i_load) begin
            valid_d = 1'b1;
            instr_d = i_instr;
            pc_d    = i_pc;
            fault_d = i_fault;
        end else if (i_clear) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: state updates use <= so every flop samples pre-edge values.
        if (!reset_n) begin
            valid_q <= 1'b0;
            instr_q <= '0;
            pc_q    <= '0;
            fault_q <= 1'b0;
        end else begin
            valid_q <= valid_d;
            instr_q <= instr_d;
            pc_q    <= pc_d;
            fault_q <= fault_d;
        end
    end

    assign o_valid = valid_q;
    assign o_instr = instr_q;
    assign o_pc    = pc_q;
    assign o_fault = fault_q;

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: one outstanding word read per PC, flush-aware, feeding decode.
// Optional feature macro: INSTRUCTION_FETCH_MISALIGN_CHECK_EN (misaligned PC -> NOP + fault).
module instruction_fetch
    import fetch_pkg::*;
#(
    parameter int DATA_WIDTH_P = 32,
    parameter int ADDR_WIDTH_P = 32
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [ADDR_WIDTH_P-1:0] i_pc,
    output logic                    o_pc_advance,
    input  logic                    i_flush,
    output logic                    o_imem_req_valid,
    output logic [ADDR_WIDTH_P-1:0] o_imem_req_addr,
    input  logic                    i_imem_req_ready,
    input  logic                    i_imem_rsp_valid,
    input  logic [DATA_WIDTH_P-1:0] i_imem_rsp_data,
    input  logic                    i_imem_rsp_err,
    output logic                    o_instr_valid,
    output logic [DATA_WIDTH_P-1:0] o_instr,
    output logic [ADDR_WIDTH_P-1:0] o_instr_pc,
    output logic                    o_fault,
    input  logic                    i_instr_ready
);

    localparam logic [ADDR_WIDTH_P-1:0] ADDR_ALIGN_MASK = ~ADDR_WIDTH_P'(FETCH_ALIGN_MASK);

    fetch_state_e            state_q, state_d;
    logic [ADDR_WIDTH_P-1:0] pc_q, pc_d;
    logic [ADDR_WIDTH_P-1:0] req_addr_q, req_addr_d;
    logic                    req_valid_q, req_valid_d;
    logic                    flush_pend_q, flush_pend_d;

    logic                    req_fire;
    logic                    flushing;
    logic                    enter_req;
    logic                    reenter_req;
    logic                    pc_advance;
    logic                    out_load;
    logic                    out_clear;
    logic [DATA_WIDTH_P-1:0] out_instr;
    logic                    out_fault;

    assign req_fire = req_valid_q & i_imem_req_ready;
    assign flushing = i_flush | flush_pend_q;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        req_addr_d   = req_addr_q;
        req_valid_d  = req_valid_q;
        flush_pend_d = flush_pend_q;
        reenter_req  = 1'b0;
        pc_advance   = 1'b0;
        out_load     = 1'b0;
        out_clear    = 1'b0;
        out_instr    = i_imem_rsp_data;
        out_fault    = i_imem_rsp_err;

        unique case (state_q)
            ST_IDLE: state_d = ST_REQ;

            ST_REQ: begin
`ifdef INSTRUCTION_FETCH_MISALIGN_CHECK_EN
                if (is_misaligned(pc_q[1:0])) begin
                    pc_advance = ~flushing;
                    if (flushing) begin
                        reenter_req = 1'b1;
                    end else begin
                        out_load  = 1'b1;
                        out_instr = DATA_WIDTH_P'(FETCH_NOP);
                        out_fault = 1'b1;
                        state_d   = ST_FULL;
                    end
                end else
`endif
                if (req_fire) begin
                    // A flush seen at any point during the request dooms its response.
                    pc_advance = ~flushing;
                    state_d    = flushing ? ST_DROP : ST_WAIT;
                end else if (i_flush) begin
                    flush_pend_d = 1'b1;
                end
            end

            ST_WAIT: begin
                if (i_imem_rsp_valid) begin
                    if (i_flush) begin
                        state_d = ST_REQ;
                    end else begin
                        out_load = 1'b1;
                        state_d  = ST_FULL;
                    end
                end else if (i_flush) begin
                    state_d = ST_DROP;
                end
            end

            ST_DROP: begin
                if (i_imem_rsp_valid) state_d = ST_REQ;
            end

            ST_FULL: begin
                if (i_instr_ready || i_flush) begin
                    out_clear = 1'b1;
                    state_d   = ST_REQ;
                end
            end

            default: state_d = ST_IDLE;
        endcase

        // Every entry into REQ samples the PC stage; the request stays frozen until accepted.
        enter_req = (state_d == ST_REQ) && ((state_q != ST_REQ) || reenter_req);
        if (enter_req) begin
            pc_d         = i_pc;
            req_addr_d   = i_pc & ADDR_ALIGN_MASK;
            flush_pend_d = 1'b0;
`ifdef INSTRUCTION_FETCH_MISALIGN_CHECK_EN
            req_valid_d  = ~is_misaligned(i_pc[1:0]);
`else
            req_valid_d  = 1'b1;
`endif
        end else if (state_d != ST_REQ) begin
            req_valid_d  = 1'b0;
            flush_pend_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            pc_q         <= '0;
            req_addr_q   <= '0;
            req_valid_q  <= 1'b0;
            flush_pend_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            req_addr_q   <= req_addr_d;
            req_valid_q  <= req_valid_d;
            flush_pend_q <= flush_pend_d;
        end
    end

    fetch_output_reg #(
        .DATA_WIDTH_P (DATA_WIDTH_P),
        .ADDR_WIDTH_P (ADDR_WIDTH_P)
    ) u_output_reg (
        .clk     (clk),
        .reset_n (reset_n),
        .i_load  (out_load),
        .i_clear (out_clear),
        .i_instr (out_instr),
        .i_pc    (pc_q),
        .i_fault (out_fault),
        .o_valid (o_instr_valid),
        .o_instr (o_instr),
        .o_pc    (o_instr_pc),
        .o_fault (o_fault)
    );

    assign o_pc_advance     = pc_advance;
    assign o_imem_req_valid = req_valid_q;
    assign o_imem_req_addr  = req_addr_q;

endmodule
